// File: rtl/joy_pkg.sv
// Shared constants for the DB9/Megadrive serial joystick decoder:
// FSM encoding, raw frame bit positions and output word bit positions.
package joy_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Per-port raw layout {pin7,pin5,pin9,pin6,right,left,down,up}, active low
    localparam int unsigned RAW_UP    = 0;
    localparam int unsigned RAW_DOWN  = 1;
    localparam int unsigned RAW_LEFT  = 2;
    localparam int unsigned RAW_RIGHT = 3;
    localparam int unsigned RAW_PIN6  = 4;
    localparam int unsigned RAW_PIN9  = 5;

    // Output layout {start,A,C,B,right,left,down,up}, active high
    localparam int unsigned OUT_A     = 6;
    localparam int unsigned OUT_START = 7;

    // {C,B,right,left,down,up} from a select=1 frame
    function automatic logic [5:0] decode_hold(input logic [7:0] raw);
        return ~{raw[RAW_PIN9], raw[RAW_PIN6], raw[RAW_RIGHT],
                 raw[RAW_LEFT], raw[RAW_DOWN], raw[RAW_UP]};
    endfunction

    // A Megadrive pad drives left and right low together while select is low
    function automatic logic md_present(input logic [7:0] raw);
        return !raw[RAW_LEFT] && !raw[RAW_RIGHT];
    endfunction

    function automatic logic [7:0] publish(input logic [5:0] hold, input logic [7:0] raw);
        logic [7:0] j;
        j = {2'b00, hold};
        if (md_present(raw)) begin
            j[OUT_A]     = ~raw[RAW_PIN6];
            j[OUT_START] = ~raw[RAW_PIN9];
        end
        return j;
    endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Half-period prescaler for the 74HC165 shift clock; tick marks the last
// clk cycle of each CLK_DIV-cycle half period, clear restarts the count.
module joy_tick_gen #(
    parameter int CLK_DIV = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/joy_db9_serial_decoder.sv
// Scans the 74HC165 chain behind both DB9 ports and decodes plain DB9 sticks
// and 3-button Megadrive pads into active-high joystick words.
module joy_db9_serial_decoder
    import joy_pkg::*;
#(
    parameter int CLK_DIV   = 32,
    parameter int NBITS     = 16,
    parameter int FRAME_GAP = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load_n,
    output logic       joy_select,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] md_detect,
    output logic       frame_done
);

    localparam int BIT_W = $clog2(NBITS + 1);
    localparam int GAP_W = $clog2(FRAME_GAP + 1);

    logic [1:0]       state, state_nxt;
    logic             phase;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [NBITS-1:0] sr;
    logic [5:0]       hold1, hold2;
    logic             tick, clear, gap_last, bit_last;

    joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    assign gap_last = (gap_cnt == GAP_W'(FRAME_GAP - 1));
    assign bit_last = (bit_cnt == BIT_W'(NBITS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable && gap_last) state_nxt = ST_LOAD;
            ST_LOAD:  if (tick && phase) state_nxt = ST_SHIFT;
            ST_SHIFT: if (tick && phase && bit_last) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Restarting the prescaler on every transition aligns each phase to its state entry
        clear = (state_nxt != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sr         <= '0;
            hold1      <= '0;
            hold2      <= '0;
            joy_clk    <= 1'b0;
            joy_load_n <= 1'b1;
            joy_select <= 1'b1;
            joy1       <= '0;
            joy2       <= '0;
            md_detect  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!enable || gap_last) gap_cnt <= '0;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                    if (state_nxt == ST_LOAD) begin
                        joy_load_n <= 1'b0;
                        phase      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        if (phase) begin
                            joy_load_n <= 1'b1;
                            phase      <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            phase <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            sr      <= {sr[NBITS-2:0], joy_data};
                            joy_clk <= 1'b1;
                            phase   <= 1'b1;
                        end else begin
                            joy_clk <= 1'b0;
                            phase   <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    joy_select <= ~joy_select;
                    if (joy_select) begin
                        hold1 <= decode_hold(sr[7:0]);
                        hold2 <= decode_hold(sr[15:8]);
                    end else begin
                        md_detect  <= {md_present(sr[15:8]), md_present(sr[7:0])};
                        joy1       <= publish(hold1, sr[7:0]);
                        joy2       <= publish(hold2, sr[15:8]);
                        frame_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_db9_serial_decoder.sv
// Directed bench for joy_db9_serial_decoder with a behavioural 74HC165 chain
// whose parallel inputs depend on the select line.
module tb_joy_db9_serial_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       joy_data;
    logic       joy_clk, joy_load_n, joy_select;
    logic [7:0] joy1, joy2;
    logic [1:0] md_detect;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    joy_db9_serial_decoder #(.CLK_DIV(4), .NBITS(16), .FRAME_GAP(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .joy_data   (joy_data),
        .joy_clk    (joy_clk),
        .joy_load_n (joy_load_n),
        .joy_select (joy_select),
        .joy1       (joy1),
        .joy2       (joy2),
        .md_detect  (md_detect),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // 74HC165 chain: parallel load while load_n low, shift on joy_clk rising edge
    logic [15:0] pat1 = 16'hFFFF;
    logic [15:0] pat0 = 16'hFFFF;
    logic [15:0] hc_sr = 16'hFFFF;
    logic        hc_clk_q = 1'b0;

    always @(posedge clk) begin
        if (!joy_load_n)            hc_sr <= joy_select ? pat1 : pat0;
        else if (joy_clk && !hc_clk_q) hc_sr <= {hc_sr[14:0], 1'b1};
        hc_clk_q <= joy_clk;
    end
    assign joy_data = hc_sr[15];

    // Timing monitor
    int   cyc = 0, load_start = 0, load_len = 0, frame_period = 0;
    int   load_pulses = 0, rise_cnt = 0, rises_last = 0, last_rise = 0, rise_period = 0;
    int   fd_cnt = 0, sel_err = 0;
    logic prev_load = 1'b1, prev_clk = 1'b0, last_sel = 1'b0, have_sel = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!joy_load_n && prev_load) begin
            if (load_pulses > 0) frame_period = cyc - load_start;
            load_start = cyc;
            rises_last = rise_cnt;
            rise_cnt   = 0;
            load_pulses++;
            if (have_sel && joy_select == last_sel) sel_err++;
            last_sel = joy_select;
            have_sel = 1'b1;
        end
        if (joy_load_n && !prev_load) load_len = cyc - load_start;
        if (joy_clk && !prev_clk) begin
            if (last_rise > 0) rise_period = cyc - last_rise;
            last_rise = cyc;
            rise_cnt++;
        end
        if (frame_done) fd_cnt++;
        prev_load = joy_load_n;
        prev_clk  = joy_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_loads(input int n);
        int target;
        target = load_pulses + n;
        for (int i = 0; i < n * 200 + 200 && load_pulses < target; i++) @(negedge clk);
        check("wait_loads_timeout", 32'(load_pulses >= target), 32'd1);
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 400 && rise_cnt != n; i++) @(negedge clk);
        check("wait_rises_timeout", 32'(rise_cnt), 32'(n));
    endtask

    int fd0, lp0, gap_n;

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_joy_clk", 32'(joy_clk), 32'd0);
        check("rst_load_n", 32'(joy_load_n), 32'd1);
        check("rst_select", 32'(joy_select), 32'd1);
        check("rst_joy1", 32'(joy1), 32'h00);
        check("rst_joy2", 32'(joy2), 32'h00);
        check("rst_md", 32'(md_detect), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // DB9 stick on port1: up + pin6 low in both frames
        pat1 = 16'hFFEE;
        pat0 = 16'hFFEE;
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        wait_loads(1);
        check("first_frame_select", 32'(joy_select), 32'd1);
        wait_loads(3);
        check("load_n_low_len", 32'(load_len), 32'd8);
        check("rises_per_frame", 32'(rises_last), 32'd16);
        check("joy_clk_period", 32'(rise_period), 32'd8);
        check("frame_period", 32'(frame_period), 32'd153);
        check("select_toggle_err", 32'(sel_err), 32'd0);

        wait_loads(1);
        check("db9_joy1", 32'(joy1), 32'h11);
        check("db9_joy2", 32'(joy2), 32'h00);
        check("db9_md", 32'(md_detect), 32'b00);
        fd0 = fd_cnt;
        wait_loads(4);
        check("frame_done_per_2_frames", 32'(fd_cnt - fd0), 32'd2);

        // Megadrive pad on port1
        pat1 = 16'hFFE7;
        pat0 = 16'hFFC3;
        wait_loads(5);
        check("md1_joy1", 32'(joy1), 32'hD8);
        check("md1_joy2", 32'(joy2), 32'h00);
        check("md1_md", 32'(md_detect), 32'b01);

        // Megadrive pad on port2 with only start pressed
        pat1 = 16'hFFFF;
        pat0 = 16'hD3FF;
        wait_loads(5);
        check("md2_joy2", 32'(joy2), 32'h80);
        check("md2_joy1", 32'(joy1), 32'h00);
        check("md2_md", 32'(md_detect), 32'b10);

        // Port2 isolation
        pat1 = 16'hFEFF;
        pat0 = 16'hFEFF;
        wait_loads(5);
        check("p2_joy2", 32'(joy2), 32'h01);
        check("p2_joy1", 32'(joy1), 32'h00);
        check("p2_md", 32'(md_detect), 32'b00);

        // Reset in the middle of SHIFT
        pat1 = 16'hFFE7;
        pat0 = 16'hFFC3;
        wait_loads(5);
        check("pre_reset_joy1", 32'(joy1), 32'hD8);
        wait_loads(1);
        wait_rises(7);
        rst_n = 1'b0;
        #1;
        check("midrst_joy1", 32'(joy1), 32'h00);
        check("midrst_md", 32'(md_detect), 32'b00);
        check("midrst_joy_clk", 32'(joy_clk), 32'd0);
        check("midrst_load_n", 32'(joy_load_n), 32'd1);
        check("midrst_select", 32'(joy_select), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        gap_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            gap_n++;
            if (!joy_load_n) break;
        end
        check("gap_after_reset", 32'(gap_n), 32'd16);
        check("post_reset_select", 32'(joy_select), 32'd1);

        // Enable dropped mid-frame: frame completes, then scanning stops
        wait_rises(3);
        enable = 1'b0;
        lp0 = load_pulses;
        wait_rises(16);
        for (int i = 0; i < 100 && joy_select != 1'b0; i++) @(negedge clk);
        check("disable_frame_completed", 32'(joy_select), 32'd0);
        repeat (500) @(negedge clk);
        check("disable_no_more_loads", 32'(load_pulses - lp0), 32'd0);
        check("disable_load_n_idle", 32'(joy_load_n), 32'd1);
        check("disable_joy1_held", 32'(joy1), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
